// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory and
// registers a valid/ready packet for decode. Optional halt via `IFETCH_HALT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_FAULT} state_t;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        valid_reg, valid_next;
  logic [31:0] opc_reg, opc_next;
  logic [31:0] oinstr_reg, oinstr_next;
  logic [31:0] oplus4_reg, oplus4_next;
  logic [31:0] fault_pc_reg, fault_pc_next;
  logic [31:0] count_reg, count_next;
  logic        handshake;
  logic        load;

  assign handshake = valid_reg && out_ready;
  assign load      = !valid_reg || out_ready;

`ifdef IFETCH_HALT_EN
  logic is_system;
  assign is_system = (imem_instr == 32'h0000_0073) || (imem_instr == 32'h0010_0073);
`endif

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    valid_next    = valid_reg;
    opc_next      = opc_reg;
    oinstr_next   = oinstr_reg;
    oplus4_next   = oplus4_reg;
    fault_pc_next = fault_pc_reg;
    count_next    = count_reg + (handshake ? 32'd1 : 32'd0);

    case (state_reg)
      S_BOOT: begin
        pc_next    = RESET_PC;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          state_next    = S_FAULT;
          fault_pc_next = redirect_target;
          valid_next    = 1'b0;
        end else if (redirect_valid) begin
          // Flush: the in-flight packet is dropped unless it handshakes now.
          pc_next    = redirect_target;
          valid_next = 1'b0;
        end else if (load) begin
          if (pc_reg >= PC_LIMIT) begin
            state_next    = S_FAULT;
            fault_pc_next = pc_reg;
            valid_next    = 1'b0;
          end else begin
            opc_next    = pc_reg;
            oinstr_next = imem_instr;
            oplus4_next = pc_reg + 32'd4;
            valid_next  = 1'b1;
            pc_next     = pc_reg + 32'd4;
`ifdef IFETCH_HALT_EN
            if (is_system) state_next = S_HALT;
`endif
          end
        end
      end
      S_HALT: begin
        // Let the last packet drain, never fetch again.
        if (handshake) valid_next = 1'b0;
      end
      S_FAULT: begin
        valid_next = 1'b0;
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_BOOT;
      pc_reg       <= RESET_PC;
      valid_reg    <= 1'b0;
      opc_reg      <= 32'd0;
      oinstr_reg   <= 32'd0;
      oplus4_reg   <= 32'd0;
      fault_pc_reg <= 32'd0;
      count_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      valid_reg    <= valid_next;
      opc_reg      <= opc_next;
      oinstr_reg   <= oinstr_next;
      oplus4_reg   <= oplus4_next;
      fault_pc_reg <= fault_pc_next;
      count_reg    <= count_next;
    end
  end

  assign imem_addr    = pc_reg;
  assign out_valid    = valid_reg;
  assign out_pc       = opc_reg;
  assign out_instr    = oinstr_reg;
  assign out_pc_plus4 = oplus4_reg;
  assign fault        = (state_reg == S_FAULT);
  assign fault_pc     = fault_pc_reg;
  assign fetch_count  = count_reg;

`ifdef IFETCH_HALT_EN
  assign halted = (state_reg == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run scored against a packet-stream model (expected next PC, transfer count).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];
  int errors = 0;
  int checks = 0;

  assign imem_instr = mem[imem_addr[7:2]];

  instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_pc_plus4(out_pc_plus4), .fault(fault),
    .fault_pc(fault_pc), .halted(halted), .fetch_count(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 64; i++) mem[i] = $urandom & 32'hFFFF_FFFC;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00a0_0113;
  endtask

  // Reset asserted between edges, released 1 ns after an edge.
  task automatic do_reset;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks += 9;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem_addr act=%h exp=0", imem_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid act=%b exp=0", out_valid); end
    if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc act=%h exp=0", out_pc); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr act=%h exp=0", out_instr); end
    if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_out_pc_plus4 act=%h exp=0", out_pc_plus4); end
    if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault act=%b exp=0", fault); end
    if (fault_pc !== 32'h0) begin errors++; $display("FAIL rst_fault_pc act=%h exp=0", fault_pc); end
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted act=%b exp=0", halted); end
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_fetch_count act=%h exp=0", fetch_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL boot_valid act=%b exp=0", out_valid); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL boot_addr act=%h exp=0", imem_addr); end
    tick;
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid act=%b exp=1", out_valid); end
    if (out_pc !== 32'h0) begin errors++; $display("FAIL first_pc act=%h exp=0", out_pc); end
    $display("reset: outputs cleared, first packet pc=%h", out_pc);
  endtask

  task automatic test_sequential;
    do_reset;
    tick;
    tick;
    for (int k = 0; k < 3; k++) begin
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] act=%b exp=1", k, out_valid); end
      if (out_pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc[%0d] act=%h exp=%h", k, out_pc, 32'(4 * k)); end
      if (out_instr !== mem[k]) begin errors++; $display("FAIL seq_instr[%0d] act=%h exp=%h", k, out_instr, mem[k]); end
      if (out_pc_plus4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL seq_plus4[%0d] act=%h exp=%h", k, out_pc_plus4, 32'(4 * k + 4)); end
      if (fetch_count !== 32'(k)) begin errors++; $display("FAIL seq_count[%0d] act=%0d exp=%0d", k, fetch_count, k); end
      $display("seq: pc=%h instr=%h count=%0d", out_pc, out_instr, fetch_count);
      if (k < 2) tick;
    end
  endtask

  // Continues from test_sequential with packet 0x8 on the output.
  task automatic test_stall;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] act=%b exp=1", c, out_valid); end
      if (out_pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] act=%h exp=8", c, out_pc); end
      if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr[%0d] act=%h exp=c", c, imem_addr); end
      if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d] act=%0d exp=2", c, fetch_count); end
    end
    out_ready = 1'b1;
    tick;
    checks += 2;
    if (out_pc !== 32'hC) begin errors++; $display("FAIL release_pc act=%h exp=c", out_pc); end
    if (fetch_count !== 32'd3) begin errors++; $display("FAIL release_count act=%0d exp=3", fetch_count); end
    $display("stall: held pc=8 for 3 cycles, released pc=%h", out_pc);
  endtask

  task automatic test_redirect;
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h20;
    tick;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble act=%b exp=0", out_valid); end
    if (imem_addr !== 32'h20) begin errors++; $display("FAIL redir_addr act=%h exp=20", imem_addr); end
    if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_count act=%0d exp=3", fetch_count); end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_valid act=%b exp=1", out_valid); end
    if (out_pc !== 32'h20) begin errors++; $display("FAIL redir_pc act=%h exp=20", out_pc); end
    if (out_instr !== mem[8]) begin errors++; $display("FAIL redir_instr act=%h exp=%h", out_instr, mem[8]); end
    $display("redirect: target 0x20 delivered after one bubble");
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    int   model_cnt;
    bit   prev_stall;
    bit   rdy;
    bit   redir;
    do_reset;
    tick;
    tick;
    exp_pc = 32'h0;
    model_cnt = 0;
    prev_stall = 1'b0;
    held_pc = 32'h0;
    held_instr = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (fetch_count !== 32'(model_cnt)) begin errors++; $display("FAIL rnd_count@%0d act=%0d exp=%0d", cyc, fetch_count, model_cnt); end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin
          errors++;
          $display("FAIL rnd_hold@%0d act=%b/%h/%h exp=1/%h/%h", cyc, out_valid, out_pc, out_instr, held_pc, held_instr);
        end
      end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0) || (exp_pc >= 32'hC0);
      if (out_valid && rdy) begin
        checks++;
        if (out_pc !== exp_pc || out_instr !== mem[exp_pc[7:2]] || out_pc_plus4 !== exp_pc + 32'd4) begin
          errors++;
          $display("FAIL rnd_pkt@%0d act=%h/%h/%h exp=%h/%h/%h", cyc, out_pc, out_instr, out_pc_plus4,
                   exp_pc, mem[exp_pc[7:2]], exp_pc + 32'd4);
        end else begin
          $display("rnd: xfer pc=%h instr=%h", out_pc, out_instr);
        end
        exp_pc += 32'd4;
        model_cnt++;
      end
      prev_stall = out_valid && !rdy && !redir;
      held_pc = out_pc;
      held_instr = out_instr;
      out_ready = rdy;
      redirect_valid = redir;
      redirect_target = 32'($urandom_range(0, 47) * 4);
      if (redir) exp_pc = redirect_target;
      tick;
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (model_cnt < 50) begin errors++; $display("FAIL rnd_throughput act=%0d exp>=50", model_cnt); end
    $display("random: %0d packets transferred", model_cnt);
  endtask

  task automatic test_end_fault;
    logic [31:0] cnt_before;
    bit found;
    do_reset;
    tick;
    redirect_valid = 1'b1;
    redirect_target = 32'hF0;
    tick;
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick;
      if (out_valid && out_pc == 32'hFC) found = 1'b1;
    end
    checks += 2;
    if (!found) begin errors++; $display("FAIL end_last_pkt act=missing exp=pc fc"); end
    if (out_instr !== mem[63]) begin errors++; $display("FAIL end_last_instr act=%h exp=%h", out_instr, mem[63]); end
    cnt_before = fetch_count;
    tick;
    checks += 5;
    if (fault !== 1'b1) begin errors++; $display("FAIL end_fault act=%b exp=1", fault); end
    if (fault_pc !== 32'h100) begin errors++; $display("FAIL end_fault_pc act=%h exp=100", fault_pc); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL end_valid act=%b exp=0", out_valid); end
    if (fetch_count !== cnt_before + 32'd1) begin errors++; $display("FAIL end_count act=%0d exp=%0d", fetch_count, cnt_before + 32'd1); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL end_addr act=%h exp=100", imem_addr); end
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    tick;
    redirect_valid = 1'b0;
    checks += 3;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL end_redir_ignored act=%h exp=100", imem_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL end_redir_valid act=%b exp=0", out_valid); end
    if (fault !== 1'b1) begin errors++; $display("FAIL end_sticky act=%b exp=1", fault); end
    $display("end: packet fc delivered, fault_pc=%h", fault_pc);
  endtask

  task automatic test_misaligned;
    logic [31:0] addr_before;
    do_reset;
    tick;
    tick;
    tick;
    addr_before = imem_addr;
    redirect_valid = 1'b1;
    redirect_target = 32'h22;
    tick;
    checks += 4;
    if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault act=%b exp=1", fault); end
    if (fault_pc !== 32'h22) begin errors++; $display("FAIL mis_fault_pc act=%h exp=22", fault_pc); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_valid act=%b exp=0", out_valid); end
    if (imem_addr !== addr_before) begin errors++; $display("FAIL mis_pc_frozen act=%h exp=%h", imem_addr, addr_before); end
    redirect_target = 32'h40;
    tick;
    redirect_valid = 1'b0;
    checks += 2;
    if (fault_pc !== 32'h22) begin errors++; $display("FAIL mis_fault_pc_hold act=%h exp=22", fault_pc); end
    if (imem_addr !== addr_before) begin errors++; $display("FAIL mis_redir_ignored act=%h exp=%h", imem_addr, addr_before); end
    $display("misaligned: redirect 0x22 faulted, later redirect ignored");
  endtask

  // Entered with the unit in FAULT from test_misaligned.
  task automatic test_reset_midop;
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (fault !== 1'b0) begin errors++; $display("FAIL mid_fault act=%b exp=0", fault); end
    if (fault_pc !== 32'h0) begin errors++; $display("FAIL mid_fault_pc act=%h exp=0", fault_pc); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr act=%h exp=0", imem_addr); end
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL mid_count act=%0d exp=0", fetch_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_run_valid act=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid act=%b exp=0", out_valid); end
    if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL mid_payload act=%h/%h/%h exp=0/0/0", out_pc, out_instr, out_pc_plus4);
    end
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL mid_count2 act=%0d exp=0", fetch_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    tick;
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid act=%b exp=1", out_valid); end
    if (out_pc !== 32'h0) begin errors++; $display("FAIL mid_restart_pc act=%h exp=0", out_pc); end
    $display("reset mid-op: outputs cleared, restart pc=%h", out_pc);
  endtask

  task automatic test_halt;
    bit found;
    mem[4] = 32'h0000_0073;
    do_reset;
    tick;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick;
      if (out_valid && out_pc == 32'h10) found = 1'b1;
    end
    checks += 2;
    if (!found) begin errors++; $display("FAIL halt_pkt act=missing exp=pc 10"); end
    if (out_instr !== 32'h0000_0073) begin errors++; $display("FAIL halt_instr act=%h exp=00000073", out_instr); end
`ifdef IFETCH_HALT_EN
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag act=%b exp=1", halted); end
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    tick;
    redirect_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain act=%b exp=0", out_valid); end
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky act=%b exp=1", halted); end
    if (imem_addr !== 32'h14) begin errors++; $display("FAIL halt_redir_ignored act=%h exp=14", imem_addr); end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_no_fetch act=%b exp=0", out_valid); end
    $display("halt: ecall at 0x10 delivered, unit halted");
`else
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_flag act=%b exp=0", halted); end
    tick;
    checks += 2;
    if (out_valid !== 1'b1 || out_pc !== 32'h14) begin errors++; $display("FAIL halt_next_pkt act=%b/%h exp=1/14", out_valid, out_pc); end
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_tied act=%b exp=0", halted); end
    $display("halt: ecall fetched as ordinary instruction, next pc=%h", out_pc);
`endif
    mem[4] = $urandom & 32'hFFFF_FFFC;
  endtask

  initial begin
    fill_mem;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_random;
    test_end_fault;
    test_misaligned;
    test_reset_midop;
    test_halt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage directly upstream of the instruction memory: owns the program counter, drives the memory's word address, and registers the returned instruction into a valid/ready IF/ID packet for decode. Handles redirects (branch/jump), decode back-pressure, misaligned/out-of-range fault detection and an optional halt on ECALL/EBREAK. The instruction memory is a combinational read (instr = mem[addr[7:2]]), so the packet is available one cycle after the PC is presented.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 64, instruction memory depth in words; legal PCs are 0 .. IMEM_WORDS*4-4.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_addr  out  32  byte address to instruction memory; always equals internal pc.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  take redirect_target as next PC this cycle.
- redirect_target  in  32  new PC.
- out_ready  in  1  decode accepts packet.
- out_valid  out  1  packet valid.
- out_pc  out  32  PC of packet.
- out_instr  out  32  instruction of packet.
- out_pc_plus4  out  32  out_pc + 4 (mod 2^32).
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  offending address captured on fault.
- halted  out  1  unit in HALT state.
- fetch_count  out  32  packets transferred (out_valid && out_ready), wraps at 2^32.

## Operation
- States: BOOT, RUN, HALT, FAULT. Reset -> BOOT.
- BOOT: pc = RESET_PC, no load; unconditionally -> RUN next edge.
- RUN, priority order each edge:
  1. redirect_valid && redirect_target[1:0] != 0 -> FAULT, fault_pc <= redirect_target, out_valid <= 0.
  2. redirect_valid (aligned) -> pc <= redirect_target, out_valid <= 0 (flush; if out_ready was high the old packet still counts as transferred).
  3. load = !out_valid || out_ready. If load and pc >= IMEM_WORDS*4 -> FAULT, fault_pc <= pc, out_valid <= 0. Else if load -> out_{pc,instr,pc_plus4} <= {pc, imem_instr, pc+4}, out_valid <= 1, pc <= pc+4.
  4. Otherwise (stalled) pc and packet hold.
- HALT: no loads, pc frozen, redirects ignored; existing packet drains normally (out_valid drops after its handshake). Exit only by reset.
- FAULT: fault = 1, out_valid = 0, pc frozen, redirects ignored. Exit only by reset.
- fetch_count increments on every out_valid && out_ready cycle in any state.
- Payload stable while out_valid && !out_ready.

## Timing
- Reset values: imem_addr = RESET_PC, out_valid 0, out_pc/out_instr/out_pc_plus4 0, fault 0, fault_pc 0, halted 0, fetch_count 0.
- First packet (pc = RESET_PC) valid 2 cycles after rst_n deasserts (BOOT cycle, then load edge).
- Steady state: one packet per cycle with out_ready held high.
- Redirect asserted cycle N: cycle N+1 out_valid = 0, imem_addr = target; cycle N+2 out_valid = 1, out_pc = target (one bubble).
- Redirect and stall in same cycle: redirect wins.
- fault and halted are registered; assert the cycle after the triggering edge.
- rst_n low mid-operation: all state and outputs return to reset values immediately, in-flight packet discarded.

## Configuration
- IFETCH_HALT_EN defined: when a load captures imem_instr == 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK), that packet is delivered and state -> HALT on the same edge; halted = 1.
- Not defined: ECALL/EBREAK fetched as ordinary instructions; HALT unreachable; halted tied 0.

## Test plan
- Reset, out_ready = 1, memory holds 0x00500093, 0x00a00113, ... -> out_pc 0x0,0x4,0x8 on consecutive cycles from cycle 2, out_instr matches, out_pc_plus4 = out_pc+4, fetch_count counts 1,2,3.
- Hold out_ready = 0 for 3 cycles with packet at pc 0x8 -> out_pc stays 0x8, imem_addr stays 0xC, fetch_count unchanged; release -> 0xC next cycle.
- redirect_valid with target 0x20 while stalled -> next cycle out_valid 0, following cycle out_pc 0x20; redirect to 0x22 -> fault = 1, fault_pc = 0x22, further redirects ignored.
- Sequential run past end (IMEM_WORDS = 64) -> packet 0xFC delivered, then fault = 1, fault_pc = 0x100, out_valid 0.
- With IFETCH_HALT_EN, ECALL at 0x10 -> packet 0x10 delivered, halted = 1, no packet 0x14, redirect ignored; without macro, 0x14 follows.
- Assert rst_n low while out_valid = 1 and fault = 1 -> all outputs reset values, restart from RESET_PC.
